dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit that sits between the core's execute/memory stage and the 512-word, word-addressed synchronous data memory. It accepts one RV32I load or store per handshake and drives the memory's address, write data and write-enable. It performs byte/halfword extraction with sign or zero extension on loads, and read-modify-write for SB/SH. It reports misaligned, illegal and out-of-range accesses as an error response without touching memory.

## Interface
- MEM_WORDS, 512: memory depth in words; byte addresses ≥ MEM_WORDS*4 are out of range.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; access aborted.
- mem_address  out  32  to memory; word index = bits [31:2].
- mem_data_in  out  32  write data to memory.
- mem_data_out  in  32  memory read data; valid the cycle after a read address is presented with mem_we=0.
- mem_we  out  1  memory write enable.

## Operation
- States: IDLE, RD, DATA, WR, RESP. Accept = req_valid & req_ready; request fields are latched into an internal request register on accept.
- On accept from IDLE, the next state is chosen as follows:
  - error → RESP with err=1.
  - load → RD.
  - SW → WR.
  - SB/SH → RD.
- Error when any of the following holds:
  - funct3 not in {000,001,010,100,101}.
  - store with funct3 100/101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - addr ≥ MEM_WORDS*4.
- RD: mem_address = latched addr, mem_we=0 → DATA.
- DATA: mem_data_out is valid.
  - Load: extract lane (byte lane addr[1:0], half lane addr[1]), sign-extend for B/H, zero-extend for BU/HU, register into resp_rdata → RESP.
  - SB/SH: merge wdata low byte/half into the read word at the lane, register into the write buffer → WR.
- WR: mem_address = addr, mem_data_in = write buffer (SB/SH) or wdata (SW), mem_we=1 → RESP.
- RESP: resp_valid=1 with resp_rdata/resp_err → IDLE.
- mem_we is 1 only in WR and is gated by !rst. mem_address is 0 in IDLE and RESP. mem_data_in is 0 outside WR.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_address=0, mem_data_in=0.
- Reset mid-operation aborts the access with no response. A WR cycle coincident with rst issues no write.
- Requests while not in IDLE are not accepted; the requester holds them.

## Timing
- Accept at cycle T. resp_valid is asserted at:
  - LW/LH/LB/LHU/LBU: T+3.
  - SW: T+2 (write in T+1).
  - SB/SH: T+4 (read T+1, merge T+2, write T+3).
  - Error: T+1, no memory activity.
- req_ready reasserts in the cycle after RESP. Next accept is possible at resp cycle +1.
- resp_rdata and resp_err hold their value after RESP until the next response; they are defined only while resp_valid=1.

## Structure
- Package dmem_lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum.
- Sub-module lsu_align (combinational): load lane extraction with sign/zero extension, and store lane merge. Shared by DATA-state logic and reused by the bench's reference model.

## Test plan
- Preload word 3 = 0x80F1_7F22. LB addr 0x0F → 0xFFFF_FF80 at T+3. LBU addr 0x0F → 0x0000_0080. LH addr 0x0C → 0x0000_7F22. LHU addr 0x0E → 0x0000_80F1.
- SW 0xDEAD_BEEF to 0x20: mem_we=1 only in T+1 with mem_address=0x20, resp at T+2. Then LW 0x20 → 0xDEAD_BEEF.
- Word 0x20 = 0xDEAD_BEEF. SB 0x0000_0055 to 0x21 → memory becomes 0xDEAD_55EF. SH 0x1234 to 0x22 → 0x1234_55EF. Each resp at T+4 with exactly one mem_we cycle.
- LW at 0x22, LH at 0x05, funct3=011, SB with funct3 100, LW at 0x800 (MEM_WORDS=512): each gives resp_err=1 at T+1 with no mem_we and no read.
- rst asserted in the WR cycle of an SW: no write occurs (memory unchanged), no resp_valid, all outputs at their reset values next cycle.
- req_valid held high across 10 back-to-back LWs: req_ready is high only in IDLE, each resp pulse lasts exactly one cycle, and results arrive in order.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I width codes,
// FSM states, the latched request record and the access legality check.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DATA,
        WR,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // True when the access must be refused without touching memory.
    function automatic logic access_err(input logic        we,
                                        input logic [2:0]  funct3,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr[0];
            F3_W:        bad = (addr[1:0] != 2'b00);
            default:     bad = 1'b1;
        endcase
        if (we && (funct3 == F3_BU || funct3 == F3_HU)) bad = 1'b1;
        if (addr >= limit) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into a previously read memory word.
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        store_word = rdata;
        case (funct3)
            F3_B:    store_word[{lane, 3'b000} +: 8]    = wdata[7:0];
            F3_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit in front of a word-addressed synchronous data memory;
// sub-word stores are done as read-modify-write, illegal accesses never reach memory.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_we
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    lsu_state_t  state, state_nx;
    lsu_req_t    req_q;
    logic [31:0] wbuf_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        acc_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign accept  = req_valid && req_ready;
    assign acc_err = access_err(req_we, req_funct3, req_addr, ADDR_LIMIT);

    lsu_align u_align (
        .rdata      (mem_data_out),
        .lane       (req_q.addr[1:0]),
        .funct3     (req_q.funct3),
        .wdata      (req_q.wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_nx    = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_address = 32'h0;
        mem_data_in = 32'h0;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (acc_err)                             state_nx = RESP;
                    else if (req_we && req_funct3 == F3_W)   state_nx = WR;
                    else                                     state_nx = RD;
                end
            end
            RD: begin
                mem_address = req_q.addr;
                state_nx    = DATA;
            end
            DATA: begin
                state_nx = req_q.we ? WR : RESP;
            end
            WR: begin
                mem_address = req_q.addr;
                mem_data_in = (req_q.funct3 == F3_W) ? req_q.wdata : wbuf_q;
                // A write coincident with reset must not reach the array.
                mem_we      = !rst;
                state_nx    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= '0;
            wbuf_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                if (acc_err) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
            // Response registers change only on entry to RESP, so they hold in between.
            if (state == DATA) begin
                if (req_q.we) begin
                    wbuf_q <= store_word;
                end else begin
                    rdata_q <= load_data;
                    err_q   <= 1'b0;
                end
            end
            if (state == WR) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-level reference model plus a per-cycle compare of
// handshake, memory port and response against the model's expected schedule.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_we;

    always #5 clk = ~clk;

    dmem_lsu #(.MEM_WORDS(512)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we)
    );

    // Synchronous data memory driven by the DUT.
    logic [31:0] mem [0:511];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem[3] <= 32'h80F1_7F22;
        end else if (mem_we) begin
            mem[mem_address[10:2]] <= mem_data_in;
        end
        mem_data_out <= mem[mem_address[10:2]];
    end

    // Reference model state: a flat byte array.
    logic [7:0] ref_b [0:2047];

    typedef struct {
        int          rd_cyc;
        int          wr_cyc;
        int          resp_cyc;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wword;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   last_resp_cyc = -1;
    int   n_total = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int t, output exp_t e);
        int     sz;
        bit     sgn;
        bit     bad;
        int     a;
        int     base;
        longint v;
        sz = 0; sgn = 1'b0; bad = 1'b0;
        case (f3)
            3'b000:  begin sz = 1; sgn = 1'b1; end
            3'b001:  begin sz = 2; sgn = 1'b1; end
            3'b010:  begin sz = 4; end
            3'b100:  begin sz = 1; end
            3'b101:  begin sz = 2; end
            default: bad = 1'b1;
        endcase
        if (we && (f3 == 3'b100 || f3 == 3'b101)) bad = 1'b1;
        if (!bad && (addr % sz) != 0) bad = 1'b1;
        if (addr >= 32'd2048) bad = 1'b1;
        e.err = bad; e.addr = addr; e.rdata = 32'h0; e.wword = 32'h0;
        e.rd_cyc = -1; e.wr_cyc = -1;
        if (bad) begin
            e.resp_cyc = t + 1;
        end else if (!we) begin
            a = int'(addr);
            v = 0;
            for (int i = 0; i < sz; i++) v = v | (longint'(ref_b[a + i]) << (8 * i));
            if (sgn && v[8 * sz - 1]) v = v - (longint'(1) << (8 * sz));
            e.rdata    = v[31:0];
            e.rd_cyc   = t + 1;
            e.resp_cyc = t + 3;
        end else begin
            a = int'(addr);
            for (int i = 0; i < sz; i++) ref_b[a + i] = wd[8 * i +: 8];
            base    = a - (a % 4);
            e.wword = {ref_b[base + 3], ref_b[base + 2], ref_b[base + 1], ref_b[base]};
            if (sz == 4) begin
                e.wr_cyc   = t + 1;
                e.resp_cyc = t + 2;
            end else begin
                e.rd_cyc   = t + 1;
                e.wr_cyc   = t + 3;
                e.resp_cyc = t + 4;
            end
        end
    endtask

    // Per-cycle compare against the model's schedule.
    bit   c_has, c_ready, c_rv, c_we;
    exp_t c_head;

    always @(negedge clk) begin
        if (chk_en) begin
            c_has   = (q.size() > 0);
            if (c_has) c_head = q[0];
            c_ready = (cyc > last_resp_cyc);
            c_rv    = c_has && (cyc == c_head.resp_cyc);
            c_we    = c_has && (cyc == c_head.wr_cyc) && !rst;
            check("req_ready", 32'(req_ready), 32'(c_ready));
            check("resp_valid", 32'(resp_valid), 32'(c_rv));
            check("mem_we", 32'(mem_we), 32'(c_we));
            if (!rst) begin
                check("mem_data_in", mem_data_in, c_we ? c_head.wword : 32'h0);
                if (c_has && (cyc == c_head.rd_cyc || cyc == c_head.wr_cyc))
                    check("mem_address", mem_address, c_head.addr);
                else if (c_ready || c_rv)
                    check("mem_address_idle", mem_address, 32'h0);
            end
            if (c_rv) begin
                check("resp_rdata", resp_rdata, c_head.rdata);
                check("resp_err", 32'(resp_err), 32'(c_head.err));
                void'(q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk); #1;
        while (cyc <= last_resp_cyc && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_total++; n_bad++;
            $display("FAIL idle_timeout: got busy want idle (cycle %0d)", cyc);
        end
    endtask

    // Presents a request at once, holds it until the model says the unit is
    // idle, then records the accept at that cycle.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit use_lit, input logic [31:0] lit,
                          input bit hold);
        exp_t e;
        int   n;
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        while (cyc <= last_resp_cyc && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_total++; n_bad++;
            $display("FAIL accept_timeout: got busy want idle (cycle %0d)", cyc);
            req_valid = 1'b0;
            return;
        end
        model_req(we, f3, addr, wd, cyc, e);
        q.push_back(e);
        last_resp_cyc = e.resp_cyc;
        if (use_lit) begin
            if (e.err)     check("model_err_lit", 32'(e.err), lit);
            else if (!we)  check("model_load_lit", e.rdata, lit);
            else           check("model_store_lit", e.wword, lit);
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_init = 1'b1;
        for (int i = 0; i < 2048; i++) ref_b[i] = 8'h00;
        ref_b[12] = 8'h22; ref_b[13] = 8'h7F; ref_b[14] = 8'hF1; ref_b[15] = 8'h80;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_err", 32'(resp_err), 32'h0);

        // Sub-word loads from word 3.
        do_req(1'b0, F3_B,  32'h0F, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
        do_req(1'b0, F3_BU, 32'h0F, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
        do_req(1'b0, F3_H,  32'h0C, 32'h0, 1'b1, 32'h0000_7F22, 1'b0);
        do_req(1'b0, F3_HU, 32'h0E, 32'h0, 1'b1, 32'h0000_80F1, 1'b0);
        do_req(1'b0, F3_B,  32'h0D, 32'h0, 1'b1, 32'h0000_007F, 1'b0);

        // Full-word and read-modify-write stores.
        do_req(1'b1, F3_W,  32'h20, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, F3_W,  32'h20, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b1, F3_B,  32'h21, 32'h0000_0055, 1'b1, 32'hDEAD_55EF, 1'b0);
        wait_idle();
        check("mem_after_sb", mem[8], 32'hDEAD_55EF);
        do_req(1'b1, F3_H,  32'h22, 32'h0000_1234, 1'b1, 32'h1234_55EF, 1'b0);
        wait_idle();
        check("mem_after_sh", mem[8], 32'h1234_55EF);
        do_req(1'b0, F3_W,  32'h20, 32'h0, 1'b1, 32'h1234_55EF, 1'b0);

        // Refused accesses.
        do_req(1'b0, F3_W,  32'h22,  32'h0, 1'b1, 32'h1, 1'b0);
        do_req(1'b0, F3_H,  32'h05,  32'h0, 1'b1, 32'h1, 1'b0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h1, 1'b0);
        do_req(1'b1, F3_BU, 32'h10,  32'h77, 1'b1, 32'h1, 1'b0);
        do_req(1'b0, F3_W,  32'h800, 32'h0, 1'b1, 32'h1, 1'b0);
        do_req(1'b0, F3_W,  32'h7FC, 32'h0, 1'b1, 32'h0, 1'b0);

        // Reset landing on the WR cycle of a SW.
        wait_idle();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
        last_resp_cyc = cyc + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rdata", resp_rdata, 32'h0);
        check("rst_mid_err", 32'(resp_err), 32'h0);
        check("rst_mid_mem", mem[16], 32'h0);
        do_req(1'b0, F3_W, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0);

        // Back-to-back loads with req_valid held high.
        for (int i = 0; i < 10; i++) begin
            case (i % 3)
                0:       do_req(1'b0, F3_W, 32'h0C, 32'h0, 1'b0, 32'h0, (i != 9));
                1:       do_req(1'b0, F3_W, 32'h20, 32'h0, 1'b0, 32'h0, (i != 9));
                default: do_req(1'b0, F3_W, 32'h40, 32'h0, 1'b0, 32'h0, (i != 9));
            endcase
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
